// File: rtl/timer_irq.sv
// Programmable down-counting timer with one-shot / auto-reload modes and a maskable interrupt.
// Dout is a combinational read of the register selected by Addr; IRQ comes straight from registered state.
module timer_irq (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        en_q, en_d;
    logic [1:0]  mode_q, mode_d;
    logic        im_q, im_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        pend_q, pend_d;
    logic        wr_ctrl, wr_preset;

    assign wr_ctrl   = WE && (Addr == 2'd0);
    assign wr_preset = WE && (Addr == 2'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            mode_q   <= 2'b00;
            im_q     <= 1'b0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        preset_d = preset_q;
        count_d  = count_q;
        pend_d   = pend_q;

        case (state_q)
            IDLE: begin
                if (en_q) state_d = LOAD;
            end
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!en_q) begin
                    state_d = IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // Saturate at zero so PRESET=0 expires like PRESET=1.
                    count_d = 32'd0;
                    pend_d  = 1'b1;
                    state_d = INT;
                end
            end
            INT: begin
                state_d = IDLE;
                if (mode_q == 2'b01) pend_d = 1'b0;
                else                 en_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // Bus writes are applied last so a CTRL write overrides the one-shot Enable clear.
        if (wr_ctrl) begin
            en_d   = Din[0];
            mode_d = Din[2:1];
            im_d   = Din[3];
        end
        if (wr_preset) preset_d = Din;
        if (wr_ctrl || wr_preset) pend_d = 1'b0;
    end

    always_comb begin
        Dout = 32'd0;
        case (Addr)
            2'd0:    Dout = {28'd0, im_q, mode_q, en_q};
            2'd1:    Dout = preset_q;
            2'd2:    Dout = count_q;
            default: Dout = 32'd0;
        endcase
    end

    assign IRQ = im_q & pend_q;

endmodule

// File: tb/tb_timer_irq.sv
// Bench for timer_irq: directed scenarios plus random register traffic, compared each cycle
// against a schedule-based reference (load edge, expiry edge, count derived arithmetically).
module tb_timer_irq;

    logic        clk;
    logic        reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int checks   = 0;
    int failures = 0;

    timer_irq dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: a run is described by the edge its count was loaded (m_t0) and its
    // starting value (m_len); the visible count and the expiry edge follow from arithmetic.
    bit          m_en, m_im;
    logic [1:0]  m_mode;
    logic [31:0] m_pre;
    bit          m_pend;
    longint      edge_no;
    longint      m_load_at;     // edge at which the next load happens, -1 if none
    bit          m_running;
    longint      m_t0, m_len;
    bit          m_expired;     // the edge after expiry applies the mode rules
    longint      m_frozen;

    function automatic void model_reset();
        m_en = 0; m_im = 0; m_mode = 2'b00; m_pre = 32'd0; m_pend = 0;
        m_load_at = -1; m_running = 0; m_t0 = 0; m_len = 0;
        m_expired = 0; m_frozen = 0;
    endfunction

    function automatic longint model_count();
        longint v;
        if (!m_running) return m_frozen;
        v = m_len - (edge_no - m_t0);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic void model_edge(bit we, logic [1:0] a, logic [31:0] d);
        longint seen = model_count();
        bit en_before = m_en;
        edge_no++;
        if (m_expired) begin
            m_expired = 0;
            if (m_mode == 2'b01) m_pend = 0;
            else                 m_en   = 0;
        end else if (m_running) begin
            if (!en_before) begin
                m_running = 0;
                m_frozen  = seen;
            end else if (edge_no == m_t0 + ((m_len < 1) ? 1 : m_len)) begin
                m_running = 0;
                m_frozen  = 0;
                m_pend    = 1;
                m_expired = 1;
            end
        end else if (m_load_at == edge_no) begin
            m_load_at = -1;
            m_running = 1;
            m_t0      = edge_no;
            m_len     = longint'(m_pre);
        end else if (en_before) begin
            m_load_at = edge_no + 1;
        end
        if (we && a == 2'd0) begin
            m_en = d[0]; m_mode = d[2:1]; m_im = d[3];
        end
        if (we && a == 2'd1) m_pre = d;
        if (we && (a == 2'd0 || a == 2'd1)) m_pend = 0;
    endfunction

    function automatic logic [31:0] model_read(logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_pre;
            2'd2:    return 32'(model_count());
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_irq"}, {31'd0, IRQ}, {31'd0, m_im & m_pend});
        for (int a = 0; a < 4; a++) begin
            Addr = 2'(a);
            #1;
            chk($sformatf("%s_dout%0d", tag, a), Dout, model_read(2'(a)));
        end
    endtask

    // Drives one cycle's bus inputs, lets the edge happen, then checks everything.
    task automatic tick(input string tag, input bit we, input logic [1:0] a, input logic [31:0] d);
        Addr = a; WE = we; Din = d;
        @(posedge clk);
        model_edge(we, a, d);
        #1;
        WE = 1'b0;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag, 1'b0, 2'd0, 32'd0);
    endtask

    initial begin
        reset = 1'b1; WE = 1'b0; Addr = 2'd0; Din = 32'd0;
        edge_no = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // One-shot: PRESET=5, CTRL=0x9 at edge k; IRQ after k+7, CTRL reads 0x8 after k+8.
        tick("os", 1'b1, 2'd1, 32'd5);
        tick("os", 1'b1, 2'd0, 32'h9);
        idle("os", 6);
        chk("os_irq_before", {31'd0, IRQ}, 32'd0);
        idle("os", 1);
        chk("os_irq_rise", {31'd0, IRQ}, 32'd1);
        idle("os", 1);
        Addr = 2'd0; #1;
        chk("os_ctrl_cleared", Dout, 32'h8);
        idle("os", 5);
        chk("os_irq_hold", {31'd0, IRQ}, 32'd1);
        tick("os", 1'b1, 2'd0, 32'h0);
        chk("os_irq_cleared", {31'd0, IRQ}, 32'd0);

        // Auto-reload: PRESET=3, CTRL=0xB; one-cycle pulses every 6 cycles.
        tick("ar", 1'b1, 2'd1, 32'd3);
        tick("ar", 1'b1, 2'd0, 32'hB);
        idle("ar", 5);
        chk("ar_first_pulse", {31'd0, IRQ}, 32'd1);
        idle("ar", 1);
        chk("ar_pulse_width", {31'd0, IRQ}, 32'd0);
        idle("ar", 5);
        chk("ar_second_pulse", {31'd0, IRQ}, 32'd1);
        idle("ar", 8);
        tick("ar", 1'b1, 2'd0, 32'h0);

        // Masked: expiry with IM=0, then enabling IM afterwards still gives no IRQ.
        tick("mk", 1'b1, 2'd1, 32'd2);
        tick("mk", 1'b1, 2'd0, 32'h1);
        idle("mk", 8);
        tick("mk", 1'b1, 2'd0, 32'h8);
        idle("mk", 3);
        chk("mk_irq", {31'd0, IRQ}, 32'd0);

        // Stop mid-count at 6, then re-enable reloads 10.
        tick("st", 1'b1, 2'd1, 32'd10);
        tick("st", 1'b1, 2'd0, 32'h9);
        for (int i = 0; i < 20 && model_count() != 7; i++) idle("st", 1);
        tick("st", 1'b1, 2'd0, 32'h8);
        idle("st", 4);
        Addr = 2'd2; #1;
        chk("st_frozen", Dout, 32'd6);
        tick("st", 1'b1, 2'd0, 32'h9);
        idle("st", 2);
        Addr = 2'd2; #1;
        chk("st_reload", Dout, 32'd10);
        tick("st", 1'b1, 2'd0, 32'h0);

        // PRESET=0 behaves as 1: IRQ after edge k+3; writes to Addr 2/3 ignored.
        tick("p0", 1'b1, 2'd1, 32'd0);
        tick("p0", 1'b1, 2'd0, 32'h9);
        idle("p0", 2);
        chk("p0_irq_before", {31'd0, IRQ}, 32'd0);
        idle("p0", 1);
        chk("p0_irq_rise", {31'd0, IRQ}, 32'd1);
        tick("ro", 1'b1, 2'd2, 32'hDEAD_BEEF);
        tick("ro", 1'b1, 2'd3, 32'h1234_5678);
        idle("ro", 2);

        // Asynchronous reset mid-count.
        tick("ar0", 1'b1, 2'd0, 32'h0);
        tick("ar0", 1'b1, 2'd1, 32'd8);
        tick("ar0", 1'b1, 2'd0, 32'h9);
        idle("ar0", 4);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("arst");
        @(negedge clk);
        reset = 1'b0;
        idle("post_rst", 15);

        // Random register traffic.
        for (int i = 0; i < 600; i++) begin
            int r = $urandom_range(0, 7);
            logic [1:0]  a = 2'($urandom_range(0, 3));
            logic [31:0] d = $urandom;
            if (a == 2'd1) d = 32'($urandom_range(0, 6));
            if (a == 2'd0 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
            tick("rnd", r == 0, a, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
